onehot_scan_decoder: RTL and testbench
======================================

Name: onehot_scan_decoder

Overview:
Parametrised binary-to-one-hot decoder with registered outputs. It generalises the fixed 4-to-16 combinational decoder in two ways: select width is a parameter, and an auto-scan mode steps the active line through 0..last with a programmable dwell time. Typical uses are display/keypad multiplexing and time-sliced channel enables. Outputs are active-high.

Parameters:
SEL_W, 4, select/index width; number of output lines OUT_W = 2**SEL_W (derived localparam, not overridable)
DWELL_W, 8, width of dwell-count input and internal dwell counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  output enable; 0 forces out to all-zero and freezes scan
mode  input  1  0 = direct decode of sel, 1 = auto-scan
sel  input  SEL_W  direct-mode select index
last  input  SEL_W  scan-mode highest index before wrap to 0
dwell  input  DWELL_W  scan step period minus 1 (cycles per index = dwell+1)
out  output  OUT_W  registered one-hot output; bit k high when index k active
idx  output  SEL_W  registered current index
wrap  output  1  one-cycle pulse when scan index returns to 0

Behaviour:
- One clock, one clock domain. Reset is asynchronous and active-low; clock port clk, reset port rst_n.
- Reset (rst_n low, asynchronous): out = 0, idx = 0, wrap = 0, dwell counter cnt = 0. Reset asserted mid-scan aborts immediately. After release, the first edge behaves as from a fresh start.
- Invariant: out always equals onehot(idx) when the last sampled en was 1, else all-zero. out and idx update on the same edge, so they never disagree.
- Direct mode (mode = 0), each edge:
  - idx <= sel.
  - out <= en ? onehot(sel) : 0.
  - cnt <= 0; wrap <= 0.
  - Latency is 1 cycle from sel/en to out.
- Scan mode (mode = 1), en = 1, each edge:
  - If cnt == dwell: cnt <= 0 and idx advances. If idx >= last, idx <= 0 and wrap <= 1; otherwise idx <= idx + 1 and wrap <= 0.
  - Else: cnt <= cnt + 1, idx holds, wrap <= 0.
  - out <= onehot(next idx).
- Scan mode, en = 0: idx and cnt hold, out <= 0, wrap <= 0. Scanning resumes from the held state when en returns to 1.
- Mode 0 -> 1: scan starts from the current idx with cnt = 0. The first advance occurs dwell+1 cycles after the first scan-mode edge.
- Mode 1 -> 0: the next edge loads sel. The scan state is discarded.
- dwell = 0: idx advances every cycle.
- dwell is sampled continuously. Lowering dwell below the current cnt does not stall: cnt counts up to its maximum, wraps to 0, and reaches dwell.
  - Implementation shall instead compare cnt >= dwell, so an advance occurs on the next edge.
- last = 0 in scan: idx stays 0 and wrap pulses once per dwell+1 cycles.
- last changed below the current idx: the next advance wraps to 0 with wrap = 1 (>= comparison).
- last = OUT_W-1: natural full-range wrap; no arithmetic overflow is relied upon.
- wrap is registered and never asserted in direct mode or while en = 0.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset and direct decode (SEL_W=4): rst_n low -> out=0, idx=0, wrap=0. Release, mode=0, en=1, sel=0,1,14,15 on successive edges -> out=0x0001, 0x0002, 0x4000, 0x8000, each one cycle after sel.
2. Enable gating: direct sel=5, en toggled 1,0,1 -> out=0x0020, 0x0000, 0x0020 while idx stays 5.
3. Scan with dwell: mode=1, en=1, last=3, dwell=2 from idx=0 -> idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap is high exactly on the cycle idx returns to 0. out tracks as 0x1, 0x2, 0x4, 0x8, 0x1.
4. Pause and boundaries: mid-scan at idx=2, en=0 for 5 cycles -> out=0, idx=2 held, no wrap; resume continues from 2. Then dwell=0, last=0 -> idx stays 0 and wrap is high every cycle.
5. Last lowered and mode switch: scanning at idx=6 with last=9, set last=4 -> next advance gives idx=0, wrap=1. Switch mode=0 with sel=11 -> next edge idx=11, out=0x0800.
6. Async reset mid-scan: assert rst_n between clock edges at idx=3 -> out, idx, wrap go to 0 immediately (before the next edge). After release, scan restarts from 0 with full dwell.

Source files
------------

// File: rtl/onehot_scan_decoder.sv
// Binary-to-one-hot decoder with registered outputs. Direct mode decodes sel; scan mode
// steps the active line 0..last and back to 0, holding each index for dwell+1 cycles.
// Latency: 1 cycle from inputs to out/idx/wrap. No backpressure; en=0 blanks out and freezes the scan.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   en           output enable (0: out all-zero, scan state held)
//   mode         0 = direct decode of sel, 1 = auto-scan
//   sel          direct-mode index
//   last         highest scan index before wrapping to 0
//   dwell        cycles per scan index minus 1
//   out          registered one-hot of idx (all-zero when the last sampled en was 0)
//   idx          registered current index
//   wrap         one-cycle pulse when the scan index returns to 0
module onehot_scan_decoder #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [SEL_W-1:0]     last,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]     idx,
  output logic                 wrap
);

  localparam int OUT_W = 2**SEL_W;

  logic [OUT_W-1:0]   out_q,  out_d;
  logic [SEL_W-1:0]   idx_q,  idx_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q,  cnt_d;

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    out_d  = '0;

    if (!mode) begin
      // Direct decode; clearing cnt means a later switch to scan starts with a full dwell.
      idx_d = sel;
      cnt_d = '0;
    end else if (en) begin
      // >= rather than == so a dwell lowered below cnt advances on the next edge
      // instead of letting cnt run all the way around.
      if (cnt_q >= dwell) begin
        cnt_d = '0;
        // >= so that last lowered below idx wraps immediately; also avoids
        // relying on idx overflow when last is the top index.
        if (idx_q >= last) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // out is derived from the next idx so the two registers never disagree.
    if (en) begin
      out_d = {{(OUT_W-1){1'b0}}, 1'b1} << idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
module tb_onehot_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [3:0]  sel;
  logic [3:0]  last;
  logic [7:0]  dwell;
  logic [15:0] out;
  logic [3:0]  idx;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .mode (mode),
    .sel  (sel),
    .last (last),
    .dwell(dwell),
    .out  (out),
    .idx  (idx),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        en;
    logic [3:0]  sel;
    logic [3:0]  last;
    logic [7:0]  dwell;
    logic [15:0] e_out;
    logic [3:0]  e_idx;
    logic        e_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic m, logic e, logic [3:0] s, logic [3:0] l, logic [7:0] d,
                             logic [15:0] eo, logic [3:0] ei, logic ew);
    vec_t r;
    r.mode = m; r.en = e; r.sel = s; r.last = l; r.dwell = d;
    r.e_out = eo; r.e_idx = ei; r.e_wrap = ew;
    return r;
  endfunction

  task automatic chk(string name, logic [15:0] eo, logic [3:0] ei, logic ew);
    checks++;
    if (out !== eo) begin
      errors++;
      $display("FAIL %s out: got %h want %h", name, out, eo);
    end
    checks++;
    if (idx !== ei) begin
      errors++;
      $display("FAIL %s idx: got %0d want %0d", name, idx, ei);
    end
    checks++;
    if (wrap !== ew) begin
      errors++;
      $display("FAIL %s wrap: got %b want %b", name, wrap, ew);
    end
  endtask

  // Drive inputs (called just after an edge), clock once, sample 1 time unit later.
  task automatic step(string name, logic m, logic e, logic [3:0] s, logic [3:0] l, logic [7:0] d,
                      logic [15:0] eo, logic [3:0] ei, logic ew);
    mode = m; en = e; sel = s; last = l; dwell = d;
    @(posedge clk);
    #1;
    chk(name, eo, ei, ew);
  endtask

  initial begin
    // Reset dominates whatever the inputs say.
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 4'd7; last = 4'd0; dwell = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 16'h0000, 4'd0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Direct decode
    vecs.push_back(v(0, 1, 4'd0,  4'd0, 8'd0, 16'h0001, 4'd0,  0));
    vecs.push_back(v(0, 1, 4'd1,  4'd0, 8'd0, 16'h0002, 4'd1,  0));
    vecs.push_back(v(0, 1, 4'd14, 4'd0, 8'd0, 16'h4000, 4'd14, 0));
    vecs.push_back(v(0, 1, 4'd15, 4'd0, 8'd0, 16'h8000, 4'd15, 0));
    // Enable gating
    vecs.push_back(v(0, 1, 4'd5,  4'd0, 8'd0, 16'h0020, 4'd5,  0));
    vecs.push_back(v(0, 0, 4'd5,  4'd0, 8'd0, 16'h0000, 4'd5,  0));
    vecs.push_back(v(0, 1, 4'd5,  4'd0, 8'd0, 16'h0020, 4'd5,  0));
    // Park at idx 0, then scan last=3 dwell=2
    vecs.push_back(v(0, 1, 4'd0,  4'd3, 8'd2, 16'h0001, 4'd0,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0001, 4'd0,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0001, 4'd0,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0002, 4'd1,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0002, 4'd1,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0002, 4'd1,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0004, 4'd2,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0004, 4'd2,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0004, 4'd2,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0008, 4'd3,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0008, 4'd3,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0008, 4'd3,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0001, 4'd0,  1));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0001, 4'd0,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0001, 4'd0,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0002, 4'd1,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0002, 4'd1,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0002, 4'd1,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0004, 4'd2,  0));
    // Pause at idx 2 (cnt 0) for 5 cycles
    for (int k = 0; k < 5; k++)
      vecs.push_back(v(1, 0, 4'd9, 4'd3, 8'd2, 16'h0000, 4'd2, 0));
    // Resume: two more dwell cycles at 2, then 3
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0004, 4'd2,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0004, 4'd2,  0));
    vecs.push_back(v(1, 1, 4'd9,  4'd3, 8'd2, 16'h0008, 4'd3,  0));
    // dwell=0, last=0: wrap every cycle
    for (int k = 0; k < 4; k++)
      vecs.push_back(v(1, 1, 4'd9, 4'd0, 8'd0, 16'h0001, 4'd0, 1));

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].mode, vecs[i].en, vecs[i].sel, vecs[i].last,
           vecs[i].dwell, vecs[i].e_out, vecs[i].e_idx, vecs[i].e_wrap);
    end

    // Last lowered below idx mid-scan, then dwell lowered below cnt, then mode switch.
    step("ld_park6",  0, 1, 4'd6,  4'd9, 8'd3, 16'h0040, 4'd6, 0);
    step("ld_s1",     1, 1, 4'd0,  4'd9, 8'd3, 16'h0040, 4'd6, 0);
    step("ld_s2",     1, 1, 4'd0,  4'd9, 8'd3, 16'h0040, 4'd6, 0);
    step("ld_s3",     1, 1, 4'd0,  4'd4, 8'd3, 16'h0040, 4'd6, 0);
    step("ld_wrap",   1, 1, 4'd0,  4'd4, 8'd3, 16'h0001, 4'd0, 1);
    step("dw_s1",     1, 1, 4'd0,  4'd4, 8'd3, 16'h0001, 4'd0, 0);
    step("dw_s2",     1, 1, 4'd0,  4'd4, 8'd3, 16'h0001, 4'd0, 0);
    step("dw_lower",  1, 1, 4'd0,  4'd4, 8'd1, 16'h0002, 4'd1, 0);
    step("mode_sw",   0, 1, 4'd11, 4'd4, 8'd1, 16'h0800, 4'd11, 0);

    // Full-range wrap at last = 15
    step("fr_park",   0, 1, 4'd14, 4'd15, 8'd0, 16'h4000, 4'd14, 0);
    step("fr_15",     1, 1, 4'd0,  4'd15, 8'd0, 16'h8000, 4'd15, 0);
    step("fr_wrap",   1, 1, 4'd0,  4'd15, 8'd0, 16'h0001, 4'd0,  1);

    // Asynchronous reset mid-scan at idx 3
    step("ar_park3",  0, 1, 4'd3,  4'd9, 8'd2, 16'h0008, 4'd3, 0);
    step("ar_s1",     1, 1, 4'd3,  4'd9, 8'd2, 16'h0008, 4'd3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_async", 16'h0000, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_held", 16'h0000, 4'd0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_first", 16'h0001, 4'd0, 1'b0);
    step("ar_s2",     1, 1, 4'd3,  4'd9, 8'd2, 16'h0001, 4'd0, 0);
    step("ar_adv",    1, 1, 4'd3,  4'd9, 8'd2, 16'h0002, 4'd1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
